// File: rtl/seq_pattern_store_pkg.sv
// Shared definitions for the sequencer pattern store: size defaults, FSM encoding, clog2 helper.
package seq_pattern_store_pkg;

    localparam int unsigned WORD_SIZE_DEF    = 8;
    localparam int unsigned ADDRESS_SIZE_DEF = 4;
    localparam int unsigned MEMORY_QTY_DEF   = 16;
    localparam int unsigned READ_LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        StInit     = 2'd0,
        StIdle     = 2'd1,
        StReadWait = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_pattern_store_if.sv
// Loader write port and sequencer read port of the pattern store, bundled as one interface.
interface seq_pattern_store_if
    import seq_pattern_store_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
    parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEF
);

    logic                    w_en;
    logic [ADDRESS_SIZE-1:0] w_addr;
    logic [WORD_SIZE-1:0]    w_data;
    logic                    w_ready;
    logic                    r_en;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0]    r_data;
    logic                    r_ready;
    logic                    addr_err;
    logic                    r_parity_err;

    modport master (
        output w_en, w_addr, w_data, r_en, r_addr,
        input  w_ready, r_data, r_ready, addr_err, r_parity_err
    );

    modport slave (
        input  w_en, w_addr, w_data, r_en, r_addr,
        output w_ready, r_data, r_ready, addr_err, r_parity_err
    );

endinterface

// File: rtl/seq_store_ram.sv
// 1W1R pattern array: synchronous write, combinational read, optional parity column
// (SEQ_STORE_PARITY_EN). Out-of-range reads return zero.
module seq_store_ram
    import seq_pattern_store_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
    parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEF,
    parameter int unsigned MEMORY_QTY   = MEMORY_QTY_DEF
) (
    input  logic                    clock,
    input  logic                    w_en_i,
    input  logic [ADDRESS_SIZE-1:0] w_addr_i,
    input  logic [WORD_SIZE-1:0]    w_data_i,
    input  logic                    w_par_i,
    input  logic [ADDRESS_SIZE-1:0] r_addr_i,
    output logic [WORD_SIZE-1:0]    r_data_o,
    output logic                    r_par_o
);

    localparam logic [ADDRESS_SIZE:0] MemQty = (ADDRESS_SIZE + 1)'(MEMORY_QTY);

    logic [WORD_SIZE-1:0] mem_q [MEMORY_QTY];
    logic                 r_in_range;

    assign r_in_range = {1'b0, r_addr_i} < MemQty;

    always_ff @(posedge clock) begin
        if (w_en_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = r_in_range ? mem_q[r_addr_i] : '0;

`ifdef SEQ_STORE_PARITY_EN
    logic [MEMORY_QTY-1:0] par_q;

    always_ff @(posedge clock) begin
        if (w_en_i) begin
            par_q[w_addr_i] <= w_par_i;
        end
    end

    assign r_par_o = r_in_range ? par_q[r_addr_i] : 1'b0;
`else
    logic unused_w_par;
    assign unused_w_par = w_par_i;
    assign r_par_o      = 1'b0;
`endif

endmodule

// File: rtl/seq_pattern_store.sv
// Pattern store feeding the sequencer: self-clearing after reset, fixed-latency reads,
// single-cycle loader writes. SEQ_STORE_PARITY_EN adds a per-word even-parity check.
module seq_pattern_store
    import seq_pattern_store_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
    parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEF,
    parameter int unsigned MEMORY_QTY   = MEMORY_QTY_DEF,
    parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
    input logic               clock,
    input logic               reset,
    seq_pattern_store_if.slave bus
);

    localparam int unsigned           LatW     = clog2(READ_LATENCY + 1);
    localparam logic [LatW-1:0]       LatLast  = LatW'(READ_LATENCY);
    localparam logic [ADDRESS_SIZE:0] MemQty   = (ADDRESS_SIZE + 1)'(MEMORY_QTY);
    localparam logic [ADDRESS_SIZE-1:0] InitLast = ADDRESS_SIZE'(MEMORY_QTY - 1);

    state_e                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] init_addr_q, init_addr_d;
    logic [ADDRESS_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [LatW-1:0]         lat_q, lat_d;
    logic [WORD_SIZE-1:0]    r_data_q, r_data_d;
    logic                    r_en_q;
    logic                    pending_q, pending_d;
    logic                    addr_err_q, addr_err_d;

    logic                    ram_we;
    logic [ADDRESS_SIZE-1:0] ram_waddr;
    logic [WORD_SIZE-1:0]    ram_wdata;
    logic                    ram_wpar;
    logic [WORD_SIZE-1:0]    ram_rdata;
    logic                    ram_rpar;

    logic rd_rise;
    logic w_in_range;
    logic r_in_range;

    assign rd_rise    = bus.r_en & ~r_en_q;
    assign w_in_range = {1'b0, bus.w_addr} < MemQty;
    assign r_in_range = {1'b0, bus.r_addr} < MemQty;

`ifdef SEQ_STORE_PARITY_EN
    logic r_par_err_q, r_par_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        rd_addr_d   = rd_addr_q;
        lat_d       = lat_q;
        r_data_d    = r_data_q;
        pending_d   = pending_q;
        addr_err_d  = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = bus.w_addr;
        ram_wdata   = bus.w_data;
        ram_wpar    = ^bus.w_data;
`ifdef SEQ_STORE_PARITY_EN
        r_par_err_d = r_par_err_q;
`endif

        unique case (state_q)
            StInit: begin
                ram_we      = 1'b1;
                ram_waddr   = init_addr_q;
                ram_wdata   = '0;
                ram_wpar    = 1'b0;
                init_addr_d = init_addr_q + 1'b1;
                // A read requested while clearing is served on the first idle cycle.
                if (rd_rise) begin
                    pending_d = 1'b1;
                end
                if (init_addr_q == InitLast) begin
                    state_d     = StIdle;
                    init_addr_d = '0;
                end
            end
            StIdle: begin
                if (rd_rise || pending_q) begin
                    state_d    = StReadWait;
                    rd_addr_d  = bus.r_addr;
                    lat_d      = LatW'(1);
                    pending_d  = 1'b0;
                    addr_err_d = ~r_in_range;
                end
            end
            StReadWait: begin
                // Word sampled at completion so writes landing during the wait are returned.
                if (lat_q == LatLast) begin
                    state_d  = StIdle;
                    r_data_d = ram_rdata;
`ifdef SEQ_STORE_PARITY_EN
                    r_par_err_d = (^ram_rdata) ^ ram_rpar;
`endif
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase

        if (state_q != StInit && bus.w_en) begin
            ram_we = w_in_range;
            if (!w_in_range) begin
                addr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StInit;
            init_addr_q <= '0;
            rd_addr_q   <= '0;
            lat_q       <= '0;
            r_data_q    <= '0;
            r_en_q      <= 1'b0;
            pending_q   <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            rd_addr_q   <= rd_addr_d;
            lat_q       <= lat_d;
            r_data_q    <= r_data_d;
            r_en_q      <= bus.r_en;
            pending_q   <= pending_d;
            addr_err_q  <= addr_err_d;
        end
    end

`ifdef SEQ_STORE_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_par_err_q <= 1'b0;
        end else begin
            r_par_err_q <= r_par_err_d;
        end
    end

    assign bus.r_parity_err = r_par_err_q;
`else
    logic unused_rpar;
    assign unused_rpar      = ram_rpar;
    assign bus.r_parity_err = 1'b0;
`endif

    assign bus.w_ready  = (state_q != StInit);
    assign bus.r_ready  = (state_q == StIdle);
    assign bus.r_data   = r_data_q;
    assign bus.addr_err = addr_err_q;

    seq_store_ram #(
        .WORD_SIZE   (WORD_SIZE),
        .ADDRESS_SIZE(ADDRESS_SIZE),
        .MEMORY_QTY  (MEMORY_QTY)
    ) u_ram (
        .clock   (clock),
        .w_en_i  (ram_we),
        .w_addr_i(ram_waddr),
        .w_data_i(ram_wdata),
        .w_par_i (ram_wpar),
        .r_addr_i(rd_addr_q),
        .r_data_o(ram_rdata),
        .r_par_o (ram_rpar)
    );

endmodule

// File: tb/tb_seq_pattern_store.sv
// Directed bench for seq_pattern_store: a 16-word instance plus a 12-word instance for
// out-of-range addressing. Parity checks switch with SEQ_STORE_PARITY_EN.
module tb_seq_pattern_store;

    logic clock = 1'b0;
    logic reset;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0] model [16];

    always #5 clock = ~clock;

    seq_pattern_store_if bus_a ();
    seq_pattern_store_if bus_b ();

    seq_pattern_store dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (bus_a)
    );

    seq_pattern_store #(
        .MEMORY_QTY(12)
    ) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_a(input logic [3:0] addr, input logic [7:0] data);
        bus_a.w_en   = 1'b1;
        bus_a.w_addr = addr;
        bus_a.w_data = data;
        step();
        bus_a.w_en = 1'b0;
        model[addr] = data;
    endtask

    // Latency 2: r_ready low after the accept edge and the next, high with data after the third.
    task automatic read_a(input logic [3:0] addr, input logic [7:0] exp, input string tag);
        bus_a.r_en   = 1'b1;
        bus_a.r_addr = addr;
        step();
        check({tag, " busy1"}, {31'd0, bus_a.r_ready}, 32'd0);
        check({tag, " no_err"}, {31'd0, bus_a.addr_err}, 32'd0);
        step();
        check({tag, " busy2"}, {31'd0, bus_a.r_ready}, 32'd0);
        step();
        check({tag, " ready"}, {31'd0, bus_a.r_ready}, 32'd1);
        check({tag, " data"}, {24'd0, bus_a.r_data}, {24'd0, exp});
        bus_a.r_en = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        bus_a.w_en = 1'b0; bus_a.w_addr = '0; bus_a.w_data = '0;
        bus_a.r_en = 1'b0; bus_a.r_addr = '0;
        bus_b.w_en = 1'b0; bus_b.w_addr = '0; bus_b.w_data = '0;
        bus_b.r_en = 1'b0; bus_b.r_addr = '0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // Reset values and 16-clock clear.
        #12;
        check("rst r_ready", {31'd0, bus_a.r_ready}, 32'd0);
        check("rst w_ready", {31'd0, bus_a.w_ready}, 32'd0);
        check("rst r_data", {24'd0, bus_a.r_data}, 32'd0);
        check("rst addr_err", {31'd0, bus_a.addr_err}, 32'd0);
        check("rst parity", {31'd0, bus_a.r_parity_err}, 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            check("init r_ready", {31'd0, bus_a.r_ready}, 32'd0);
        end
        step();
        check("init done r_ready", {31'd0, bus_a.r_ready}, 32'd1);
        check("init done w_ready", {31'd0, bus_a.w_ready}, 32'd1);
        for (int a = 0; a < 16; a++) read_a(4'(a), 8'h00, "clear");

        // Basic write then read.
        write_a(4'd3, 8'hA5);
        read_a(4'd3, 8'hA5, "rd3");

        // Same-cycle write and read rise, then a write during READ_WAIT.
        bus_a.w_en = 1'b1; bus_a.w_addr = 4'd5; bus_a.w_data = 8'h3C;
        bus_a.r_en = 1'b1; bus_a.r_addr = 4'd5;
        step();
        bus_a.w_en = 1'b0;
        model[5] = 8'h3C;
        check("same busy1", {31'd0, bus_a.r_ready}, 32'd0);
        step();
        check("same busy2", {31'd0, bus_a.r_ready}, 32'd0);
        step();
        check("same ready", {31'd0, bus_a.r_ready}, 32'd1);
        check("same data", {24'd0, bus_a.r_data}, 32'h3C);
        bus_a.r_en = 1'b0;
        step();
        bus_a.r_en = 1'b1;
        step();
        bus_a.w_en = 1'b1; bus_a.w_addr = 4'd5; bus_a.w_data = 8'h5A;
        step();
        bus_a.w_en = 1'b0;
        model[5] = 8'h5A;
        check("wait-wr busy", {31'd0, bus_a.r_ready}, 32'd0);
        step();
        check("wait-wr ready", {31'd0, bus_a.r_ready}, 32'd1);
        check("wait-wr data", {24'd0, bus_a.r_data}, 32'h5A);
        bus_a.r_en = 1'b0;
        step();

        // Sequencer-style traffic: random 1-3 clock gaps between reads.
        for (int i = 0; i < 8; i++) write_a(4'(8 + i), 8'(8'hC1 + 8'(i * 7)));
        for (int k = 0; k < 12; k++) begin
            logic [3:0] ra;
            ra = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) step();
            read_a(ra, model[ra], "seq");
        end

        // Parity column.
        write_a(4'd7, 8'h01);
        read_a(4'd7, 8'h01, "par clean");
        check("par clean err", {31'd0, bus_a.r_parity_err}, 32'd0);
`ifdef SEQ_STORE_PARITY_EN
        force dut_a.u_ram.par_q[7] = 1'b0;
        read_a(4'd7, 8'h01, "par flip");
        check("par flip err", {31'd0, bus_a.r_parity_err}, 32'd1);
        release dut_a.u_ram.par_q[7];
`endif

        // 12-word instance: out-of-range write and read.
        bus_b.w_en = 1'b1; bus_b.w_addr = 4'd2; bus_b.w_data = 8'h77;
        step();
        bus_b.w_en = 1'b0;
        bus_b.r_en = 1'b1; bus_b.r_addr = 4'd2;
        step(); step(); step();
        check("b rd2 ready", {31'd0, bus_b.r_ready}, 32'd1);
        check("b rd2 data", {24'd0, bus_b.r_data}, 32'h77);
        bus_b.r_en = 1'b0;
        step();
        bus_b.w_en = 1'b1; bus_b.w_addr = 4'hD; bus_b.w_data = 8'hFF;
        step();
        bus_b.w_en = 1'b0;
        check("b wr oob err", {31'd0, bus_b.addr_err}, 32'd1);
        step();
        check("b wr oob pulse", {31'd0, bus_b.addr_err}, 32'd0);
        bus_b.r_en = 1'b1; bus_b.r_addr = 4'hF;
        step();
        check("b rd oob err", {31'd0, bus_b.addr_err}, 32'd1);
        check("b rd oob busy", {31'd0, bus_b.r_ready}, 32'd0);
        step();
        check("b rd oob pulse", {31'd0, bus_b.addr_err}, 32'd0);
        step();
        check("b rd oob ready", {31'd0, bus_b.r_ready}, 32'd1);
        check("b rd oob data", {24'd0, bus_b.r_data}, 32'd0);
        bus_b.r_en = 1'b0;
        step();

        // Reset in the middle of a read.
        bus_a.r_en = 1'b1; bus_a.r_addr = 4'd3;
        step();
        check("mid busy", {31'd0, bus_a.r_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mid rst r_ready", {31'd0, bus_a.r_ready}, 32'd0);
        check("mid rst w_ready", {31'd0, bus_a.w_ready}, 32'd0);
        check("mid rst r_data", {24'd0, bus_a.r_data}, 32'd0);
        bus_a.r_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // Read requested during the clear is served right after it.
        step(); step(); step();
        bus_a.r_en = 1'b1; bus_a.r_addr = 4'd0;
        repeat (12) step();
        check("pend init", {31'd0, bus_a.r_ready}, 32'd0);
        step();
        check("pend idle", {31'd0, bus_a.r_ready}, 32'd1);
        step();
        check("pend busy1", {31'd0, bus_a.r_ready}, 32'd0);
        step();
        check("pend busy2", {31'd0, bus_a.r_ready}, 32'd0);
        step();
        check("pend ready", {31'd0, bus_a.r_ready}, 32'd1);
        check("pend data", {24'd0, bus_a.r_data}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("held no retrigger", {31'd0, bus_a.r_ready}, 32'd1);
        end
        bus_a.r_en = 1'b0;
        step();
        read_a(4'd3, model[3], "cleared rd3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
